// File: rtl/inst_fetch_queue_if.sv
// Bundle of fetch-side push signals and decode-side pop/peek signals
// for the instruction fetch queue.
interface inst_fetch_queue_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid1;
  logic          in_valid2;
  logic [DW-1:0] in_inst1;
  logic [DW-1:0] in_inst2;
  logic [AW-1:0] in_addr1;
  logic [AW-1:0] in_addr2;
  logic [1:0]    issue_num;
  logic          out_valid1;
  logic          out_valid2;
  logic [DW-1:0] out_inst1;
  logic [DW-1:0] out_inst2;
  logic [AW-1:0] out_addr1;
  logic [AW-1:0] out_addr2;
  logic          fetch_stall;
  logic [CW-1:0] count;

  modport master (
    output flush, in_valid1, in_valid2, in_inst1, in_inst2, in_addr1, in_addr2, issue_num,
    input  out_valid1, out_valid2, out_inst1, out_inst2, out_addr1, out_addr2,
           fetch_stall, count
  );

  modport slave (
    input  flush, in_valid1, in_valid2, in_inst1, in_inst2, in_addr1, in_addr2, issue_num,
    output out_valid1, out_valid2, out_inst1, out_inst2, out_addr1, out_addr2,
           fetch_stall, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction fetch queue: circular buffer accepting up to two
// fetched words per cycle and presenting the two oldest entries to decode.
module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic             clk,
  input logic             rst,
  inst_fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] inst_mem [DEPTH];
  logic [AW-1:0] addr_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic [CW-1:0] cnt;
  logic [CW-1:0] push_num;
  logic [CW-1:0] pop_req;
  logic [CW-1:0] pop_num;
  logic          stall;

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);

  // Stall whenever fewer than two slots are free, so a dual push can never overflow.
  assign stall = (cnt > CW'(DEPTH - 2));

  always_comb begin
    push_num = '0;
    if (!stall && bus.in_valid1) begin
      push_num = bus.in_valid2 ? CW'(2) : CW'(1);
    end
  end

  always_comb begin
    pop_req = '0;
    case (bus.issue_num)
      2'd0:    pop_req = '0;
      2'd1:    pop_req = CW'(1);
      default: pop_req = CW'(2);
    endcase
    pop_num = (pop_req > cnt) ? cnt : pop_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + pop_num[PW-1:0];
      tail <= tail + push_num[PW-1:0];
      cnt  <= cnt + push_num - pop_num;
    end
  end

  // Storage carries no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (!bus.flush && push_num != '0) begin
      inst_mem[tail] <= bus.in_inst1;
      addr_mem[tail] <= bus.in_addr1;
      if (push_num == CW'(2)) begin
        inst_mem[tail_p1] <= bus.in_inst2;
        addr_mem[tail_p1] <= bus.in_addr2;
      end
    end
  end

  assign bus.out_valid1  = (cnt != '0);
  assign bus.out_valid2  = (cnt >= CW'(2));
  assign bus.out_inst1   = inst_mem[head];
  assign bus.out_addr1   = addr_mem[head];
  assign bus.out_inst2   = inst_mem[head_p1];
  assign bus.out_addr2   = addr_mem[head_p1];
  assign bus.fetch_stall = stall;
  assign bus.count       = cnt;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios followed by a
// randomized run, compared against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] inst;
  } entry_t;

  logic   clk;
  logic   rst;
  entry_t model_q[$];
  int     vectors;
  int     miscompares;

  inst_fetch_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".count"}, 64'(bus.count), 64'(n));
    check({tag, ".valid1"}, 64'(bus.out_valid1), 64'(n >= 1));
    check({tag, ".valid2"}, 64'(bus.out_valid2), 64'(n >= 2));
    check({tag, ".stall"}, 64'(bus.fetch_stall), 64'((DEPTH - n) < 2));
    if (n >= 1) begin
      check({tag, ".addr1"}, 64'(bus.out_addr1), 64'(model_q[0].addr));
      check({tag, ".inst1"}, 64'(bus.out_inst1), 64'(model_q[0].inst));
    end
    if (n >= 2) begin
      check({tag, ".addr2"}, 64'(bus.out_addr2), 64'(model_q[1].addr));
      check({tag, ".inst2"}, 64'(bus.out_inst2), 64'(model_q[1].inst));
    end
  endtask

  // Drives one cycle of inputs, advances the model at the edge, checks at the next negedge.
  task automatic apply_stimulus(input string tag, input logic v1, input logic v2,
                                input logic [AW-1:0] a1, input logic [DW-1:0] i1,
                                input logic [AW-1:0] a2, input logic [DW-1:0] i2,
                                input logic [1:0] issue, input logic fl);
    bit exp_stall;
    int pops;
    bus.in_valid1 = v1;
    bus.in_valid2 = v2;
    bus.in_addr1  = a1;
    bus.in_inst1  = i1;
    bus.in_addr2  = a2;
    bus.in_inst2  = i2;
    bus.issue_num = issue;
    bus.flush     = fl;
    exp_stall = (DEPTH - model_q.size()) < 2;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      pops = (issue == 2'd3) ? 2 : int'(issue);
      if (pops > model_q.size()) pops = model_q.size();
      repeat (pops) void'(model_q.pop_front());
      if (!exp_stall && v1) begin
        model_q.push_back('{addr: a1, inst: i1});
        if (v2) model_q.push_back('{addr: a2, inst: i2});
      end
    end
    @(negedge clk);
    bus.in_valid1 = 1'b0;
    bus.in_valid2 = 1'b0;
    bus.issue_num = 2'd0;
    bus.flush     = 1'b0;
    check_output(tag);
  endtask

  task automatic push2(input string tag, input logic [AW-1:0] a, input logic [1:0] issue);
    apply_stimulus(tag, 1'b1, 1'b1, a, 32'hA000_0000 ^ a, a + 4, 32'hA000_0000 ^ (a + 4), issue, 1'b0);
  endtask

  task automatic push1(input string tag, input logic [AW-1:0] a, input logic [1:0] issue);
    apply_stimulus(tag, 1'b1, 1'b0, a, 32'hA000_0000 ^ a, '0, '0, issue, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_q.delete();
    check_output(tag);
    @(negedge clk);
    rst = 1'b1;
    check_output({tag, ".after"});
  endtask

  initial begin
    logic       v1;
    logic       v2;
    logic [1:0] iss;
    logic       fl;
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid1 = 1'b0;
    bus.in_valid2 = 1'b0;
    bus.in_addr1  = '0;
    bus.in_addr2  = '0;
    bus.in_inst1  = '0;
    bus.in_inst2  = '0;
    bus.issue_num = 2'd0;
    #1;
    check_output("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    push2("first_pair", 32'h1000, 2'd0);
    check("first_pair.addr1_abs", 64'(bus.out_addr1), 64'h1000);
    check("first_pair.addr2_abs", 64'(bus.out_addr2), 64'h1004);

    push1("fill_single", 32'h1008, 2'd0);
    push2("fill_a", 32'h100C, 2'd0);
    push2("fill_b", 32'h1014, 2'd0);
    check("fill.count7", 64'(bus.count), 64'd7);
    check("fill.stall7", 64'(bus.fetch_stall), 64'd1);
    push2("fill_ignored", 32'h2000, 2'd0);
    check("fill_ignored.count", 64'(bus.count), 64'd7);

    apply_stimulus("drain_a", 1'b0, 1'b0, '0, '0, '0, '0, 2'd2, 1'b0);
    apply_stimulus("drain_b", 1'b0, 1'b0, '0, '0, '0, '0, 2'd2, 1'b0);
    push2("push_pop_same", 32'h3000, 2'd2);
    check("push_pop_same.count3", 64'(bus.count), 64'd3);

    apply_stimulus("to_one", 1'b0, 1'b0, '0, '0, '0, '0, 2'd2, 1'b0);
    apply_stimulus("underflow", 1'b0, 1'b0, '0, '0, '0, '0, 2'd2, 1'b0);
    check("underflow.count0", 64'(bus.count), 64'd0);

    push2("pre_flush_a", 32'h4000, 2'd0);
    push2("pre_flush_b", 32'h4008, 2'd0);
    push1("pre_flush_c", 32'h4010, 2'd0);
    apply_stimulus("flush", 1'b1, 1'b1, 32'h5000, 32'h1, 32'h5004, 32'h2, 2'd1, 1'b1);
    check("flush.count0", 64'(bus.count), 64'd0);

    for (int k = 0; k < 10; k++) begin
      push2("seq", 32'(k * 8), 2'd2);
    end
    apply_stimulus("seq_drain", 1'b0, 1'b0, '0, '0, '0, '0, 2'd3, 1'b0);

    push2("pre_reset_a", 32'h6000, 2'd0);
    push2("pre_reset_b", 32'h6008, 2'd0);
    pulse_reset("mid_reset");

    for (int k = 0; k < 300; k++) begin
      v1  = 1'($urandom_range(0, 3) != 0);
      v2  = v1 & 1'($urandom);
      iss = 2'($urandom);
      fl  = ($urandom_range(0, 29) == 0);
      apply_stimulus("rand", v1, v2, $urandom, $urandom, $urandom, $urandom, iss, fl);
      if (k == 150) pulse_reset("rand_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two, at least 4).
REQ-002 SHALL have parameter AW, default 32, instruction address width.
REQ-003 SHALL have parameter DW, default 32, instruction word width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  discards all queue contents (branch or exception redirect).
REQ-007 SHALL have port in_valid1  input  1  slot-1 fetch data valid.
REQ-008 SHALL have port in_valid2  input  1  slot-2 fetch data valid; legal only with in_valid1=1.
REQ-009 SHALL have port in_inst1 / in_inst2  input  DW each  fetched instruction words.
REQ-010 SHALL have port in_addr1 / in_addr2  input  AW each  virtual addresses of the fetched words.
REQ-011 SHALL have port issue_num  input  2  number of entries decode consumes this cycle (0, 1 or 2).
REQ-012 SHALL have port out_valid1 / out_valid2  output  1 each  head entry / head+1 entry valid.
REQ-013 SHALL have port out_inst1 / out_inst2  output  DW each  head / head+1 instruction.
REQ-014 SHALL have port out_addr1 / out_addr2  output  AW each  head / head+1 address.
REQ-015 SHALL have port fetch_stall  output  1  fetch must hold; fewer than 2 free entries.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL implement a circular buffer with head pointer, tail pointer and occupancy counter, all wrapping modulo DEPTH.
REQ-018 SHALL write at the clock edge only when fetch_stall=0: 1 entry if in_valid1 only, 2 entries (slot 1 at tail, slot 2 at tail+1) if both valid.
REQ-019 SHALL ignore in_valid1/in_valid2 while fetch_stall=1 (no write, no pointer change).
REQ-020 SHALL ignore in_valid2 when in_valid1=0.
REQ-021 SHALL pop min(issue_num, count) entries at the clock edge, advancing head by that amount; issue_num=3 is treated as 2.
REQ-022 SHALL handle simultaneous push and pop in one cycle: count_next = count + pushed - popped.
REQ-023 SHALL drive outputs combinationally from registered state only: out_valid1 = (count>=1), out_valid2 = (count>=2), out_* from entries head and head+1 (modulo DEPTH).
REQ-024 SHALL NOT bypass: an entry written in cycle N is visible on outputs no earlier than cycle N+1.
REQ-025 SHALL assert fetch_stall = (DEPTH - count < 2), evaluated from registered count.
REQ-026 SHALL give flush priority over push and pop: at the edge with flush=1, head, tail and count become 0 and same-cycle push/pop are discarded.
REQ-027 SHALL keep out_inst/out_addr of invalid slots don't-care; only out_valid qualifies them.
REQ-028 SHALL never overflow or underflow count under any input combination.

Reset
REQ-029 SHALL, while rst=0, immediately force head=0, tail=0, count=0, out_valid1=0, out_valid2=0, fetch_stall=0.
REQ-030 SHALL NOT require entry storage to be reset; storage contents are unspecified after reset.
REQ-031 SHALL resume normal operation at the first rising edge after rst deasserts; reset asserted mid-operation discards all entries.

Verification
REQ-032 SHALL verify: reset, then push (0x1000,I0),(0x1004,I1) with issue_num=0 -> next cycle count=2, out_addr1=0x1000, out_addr2=0x1004, both valid.
REQ-033 SHALL verify: fill with dual pushes, issue_num=0 until count=7 (DEPTH=8) -> fetch_stall=1, further pushes ignored, count stays 7.
REQ-034 SHALL verify: count=3, dual push plus issue_num=2 same cycle -> count=3, head advanced by 2, FIFO order preserved.
REQ-035 SHALL verify: count=1, issue_num=2 -> only 1 popped, count=0, out_valid1=0.
REQ-036 SHALL verify: count=5, flush=1 with dual push and issue_num=1 -> next cycle count=0, out_valid1=0, fetch_stall=0.
REQ-037 SHALL verify: push 20 sequential addresses 0x0..0x4C with issue_num=2 each cycle -> pointers wrap, outputs appear in exact address order, no loss or duplication; rst pulsed low mid-run -> count=0 immediately.
